dl_object_fetcher: RTL

- Display-list object fetcher; sits directly upstream of the Maria line RAM writer.
- Walks one zone's display list, decodes 4- and 5-byte object headers, fetches graphics bytes (direct or indirect/character mode), and presents each byte with hpos/palette/write-mode as one latch strobe.
- Terminates on the end-of-list header and pulses done.

---
 rtl/maria_pkg.sv | 30 +++
 rtl/dl_mem_port.sv | 37 +++
 rtl/dl_object_fetcher.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/maria_pkg.sv
// Shared types and constants for the Maria display-list object fetcher.
// Holds the walker state encoding, header byte offsets and header decode constants.
package maria_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CLR,
        ST_PTR,
        ST_GFX,
        ST_LATCH,
        ST_DONE
    } fetch_state_t;

    localparam logic [2:0] HDR_B0 = 3'd0;
    localparam logic [2:0] HDR_B1 = 3'd1;
    localparam logic [2:0] HDR_B2 = 3'd2;
    localparam logic [2:0] HDR_B3 = 3'd3;
    localparam logic [2:0] HDR_B4 = 3'd4;

    localparam logic [4:0] EXT_HDR_MASK = 5'b00000;
    localparam logic [7:0] END_B1       = 8'h00;
    localparam logic [5:0] WIDTH_BASE   = 6'd32;

    // Width field is stored as a two's-complement count; width 0 means 32 bytes.
    function automatic logic [5:0] byte_count(input logic [4:0] width);
        return WIDTH_BASE - {1'b0, width};
    endfunction

endpackage

// File: rtl/dl_mem_port.sv
// Request/acknowledge holder: captures an address on rd_start and holds
// mem_req and mem_addr steady until the memory acknowledges.
module dl_mem_port #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_sys,
    input  logic              RESET_N,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              data_valid
);

    logic              mem_req_reg;
    logic [ADDR_W-1:0] mem_addr_reg;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
        end else if (mem_req_reg) begin
            if (mem_ack) begin
                mem_req_reg <= 1'b0;
            end
        end else if (rd_start) begin
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= rd_addr;
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign data_valid = mem_req_reg & mem_ack;

endmodule

// File: rtl/dl_object_fetcher.sv
// Walks one zone's display list, decodes object headers, fetches graphics
// bytes (direct or character-indirect) and strobes them into the line RAM.
module dl_object_fetcher
    import maria_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MAX_OBJ = 64
) (
    input  logic              clk_sys,
    input  logic              RESET_N,
    input  logic              mclk0,
    input  logic              dl_start,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [3:0]        zone_offset,
    input  logic [7:0]        CHARBASE,
    input  logic              CWIDTH,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [7:0]        hpos,
    output logic [2:0]        PALETTE,
    output logic [7:0]        PIXELS,
    output logic              WM,
    output logic              latch_byte,
    output logic              clear_hpos,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int CNT_W = $clog2(MAX_OBJ + 1);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [2:0]        hdr_idx_reg;
    logic              ext_reg;
    logic              ind_reg;
    logic              wm_reg;
    logic              second_reg;
    logic [7:0]        b0_reg;
    logic [7:0]        b2_reg;
    logic [7:0]        char_reg;
    logic [2:0]        pal_reg;
    logic [5:0]        n_reg;
    logic [5:0]        i_reg;
    logic [CNT_W-1:0]  obj_cnt_reg;
    logic [7:0]        hpos_reg;
    logic [2:0]        palette_reg;
    logic [7:0]        pixels_reg;
    logic              wm_out_reg;
    logic              overrun_reg;

    logic              data_valid;
    logic              rd_start;
    logic [ADDR_W-1:0] fetch_addr;
    logic [15:0]       addr16;
    logic [7:0]        dgfx_hi;
    logic [7:0]        cgfx_hi;

    assign dgfx_hi = b2_reg + {4'd0, zone_offset};
    assign cgfx_hi = CHARBASE + {4'd0, zone_offset};

    always_comb begin
        addr16 = 16'd0;
        case (state_reg)
            ST_PTR:  addr16 = {b2_reg, b0_reg} + {10'd0, i_reg};
            ST_GFX:  addr16 = ind_reg ? ({cgfx_hi, char_reg} + {15'd0, second_reg})
                                      : ({dgfx_hi, b0_reg} + {10'd0, i_reg});
            default: addr16 = 16'd0;
        endcase
    end

    assign fetch_addr = (state_reg == ST_HDR) ? ptr_reg : ADDR_W'(addr16);

    // A new request is launched on the first idle cycle of any fetching state,
    // so mem_req rises one cycle after the state is entered or after the last ack.
    assign rd_start = ((state_reg == ST_HDR) || (state_reg == ST_PTR) || (state_reg == ST_GFX))
                      && !mem_req;

    dl_mem_port #(
        .ADDR_W (ADDR_W)
    ) u_mem_port (
        .clk_sys    (clk_sys),
        .RESET_N    (RESET_N),
        .rd_start   (rd_start),
        .rd_addr    (fetch_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .data_valid (data_valid)
    );

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            hdr_idx_reg <= HDR_B0;
            ext_reg     <= 1'b0;
            ind_reg     <= 1'b0;
            wm_reg      <= 1'b0;
            second_reg  <= 1'b0;
            b0_reg      <= 8'd0;
            b2_reg      <= 8'd0;
            char_reg    <= 8'd0;
            pal_reg     <= 3'd0;
            n_reg       <= 6'd0;
            i_reg       <= 6'd0;
            obj_cnt_reg <= '0;
            hpos_reg    <= 8'd0;
            palette_reg <= 3'd0;
            pixels_reg  <= 8'd0;
            wm_out_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (dl_start) begin
                        ptr_reg     <= dl_addr;
                        wm_reg      <= 1'b0;
                        overrun_reg <= 1'b0;
                        obj_cnt_reg <= '0;
                        hdr_idx_reg <= HDR_B0;
                        state_reg   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (data_valid) begin
                        ptr_reg     <= ptr_reg + ADDR_W'(1);
                        hdr_idx_reg <= hdr_idx_reg + 3'd1;
                        case (hdr_idx_reg)
                            HDR_B0: b0_reg <= mem_data;
                            HDR_B1: begin
                                if (mem_data == END_B1) begin
                                    state_reg <= ST_DONE;
                                end else if (mem_data[4:0] == EXT_HDR_MASK) begin
                                    ext_reg <= 1'b1;
                                    wm_reg  <= mem_data[7];
                                    ind_reg <= mem_data[5];
                                end else begin
                                    ext_reg <= 1'b0;
                                    ind_reg <= 1'b0;
                                    pal_reg <= mem_data[7:5];
                                    n_reg   <= byte_count(mem_data[4:0]);
                                end
                            end
                            HDR_B2: b2_reg <= mem_data;
                            HDR_B3: begin
                                if (ext_reg) begin
                                    pal_reg <= mem_data[7:5];
                                    n_reg   <= byte_count(mem_data[4:0]);
                                end else begin
                                    hpos_reg    <= mem_data;
                                    palette_reg <= pal_reg;
                                    wm_out_reg  <= wm_reg;
                                    i_reg       <= 6'd0;
                                    second_reg  <= 1'b0;
                                    state_reg   <= ST_CLR;
                                end
                            end
                            HDR_B4: begin
                                hpos_reg    <= mem_data;
                                palette_reg <= pal_reg;
                                wm_out_reg  <= wm_reg;
                                i_reg       <= 6'd0;
                                second_reg  <= 1'b0;
                                state_reg   <= ST_CLR;
                            end
                            default: state_reg <= ST_IDLE;
                        endcase
                    end
                end
                ST_CLR: begin
                    if (mclk0) begin
                        state_reg <= ind_reg ? ST_PTR : ST_GFX;
                    end
                end
                ST_PTR: begin
                    if (data_valid) begin
                        char_reg  <= mem_data;
                        state_reg <= ST_GFX;
                    end
                end
                ST_GFX: begin
                    if (data_valid) begin
                        pixels_reg <= mem_data;
                        state_reg  <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (mclk0) begin
                        if (ind_reg && CWIDTH && !second_reg) begin
                            second_reg <= 1'b1;
                            state_reg  <= ST_GFX;
                        end else begin
                            second_reg <= 1'b0;
                            if ((i_reg + 6'd1) == n_reg) begin
                                obj_cnt_reg <= obj_cnt_reg + CNT_W'(1);
                                if (obj_cnt_reg == CNT_W'(MAX_OBJ - 1)) begin
                                    overrun_reg <= 1'b1;
                                    state_reg   <= ST_DONE;
                                end else begin
                                    hdr_idx_reg <= HDR_B0;
                                    state_reg   <= ST_HDR;
                                end
                            end else begin
                                i_reg     <= i_reg + 6'd1;
                                state_reg <= ind_reg ? ST_PTR : ST_GFX;
                            end
                        end
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Strobes are qualified by the live mclk0 so the line RAM always sees them
    // in a cycle it samples; the state holds until that cycle arrives.
    assign latch_byte = (state_reg == ST_LATCH) && mclk0;
    assign clear_hpos = (state_reg == ST_CLR) && mclk0;
    assign done       = (state_reg == ST_DONE);
    assign busy       = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign hpos       = hpos_reg;
    assign PALETTE    = palette_reg;
    assign PIXELS     = pixels_reg;
    assign WM         = wm_out_reg;
    assign overrun    = overrun_reg;

endmodule
